// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and instruction-format constants.
// Imported by cpu_mc and cpu_alu.
package cpu_pkg;

  localparam int NWORDS = 4;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_LD   = 8'h01;
  localparam logic [7:0] OP_ST   = 8'h02;
  localparam logic [7:0] OP_LDI  = 8'h03;
  localparam logic [7:0] OP_MOV  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_OR   = 8'h08;
  localparam logic [7:0] OP_XOR  = 8'h09;
  localparam logic [7:0] OP_ROTL = 8'h0A;
  localparam logic [7:0] OP_ROTR = 8'h0B;
  localparam logic [7:0] OP_JMP  = 8'h0C;
  localparam logic [7:0] OP_BZ   = 8'h0D;
  localparam logic [7:0] OP_BNZ  = 8'h0E;
  localparam logic [7:0] OP_NOP  = 8'hFF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALTED
  } state_t;

  function automatic int ir_width(input int dw);
    return NWORDS * dw;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: op, a, b -> result, zero, writes_reg.
// Covers LDI (b passes through), MOV, arithmetic, logic and rotates.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              writes_reg
);

  localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] inv;

  // A shift of DATA_W drains to zero, so sh==0 yields a unchanged.
  assign sh  = b % DW;
  assign inv = DW - sh;

  always_comb begin
    result     = '0;
    writes_reg = 1'b1;
    unique case (op)
      OP_LDI:  result = b;
      OP_MOV:  result = a;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_ROTL: result = (a << sh) | (a >> inv);
      OP_ROTR: result = (a >> sh) | (a << inv);
      default: writes_reg = 1'b0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle register CPU on a single req/ready memory bus.
// Ports: clk, rst (sync, active-low), mem_* bus master, halted, pc.
module cpu_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int RW = $clog2(NREGS);

  state_t state, state_nx;
  logic              run;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir [NWORDS];
  logic              z;
  logic [DATA_W-1:0] rf [NREGS];

  logic [7:0]        op;
  logic [RW-1:0]     d_i, a_i, b_i;
  logic [ADDR_W-1:0] tgt, pc_inc;
  logic [DATA_W-1:0] ra, rb, rd;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_z, alu_wr;
  logic              done, is_ld, is_st;

  // Wide op fields with high bits set decode as NOP.
  assign op = ((ir[0] >> 8) != '0)
            ? OP_NOP : ir[0][7:0];

  assign d_i    = RW'(ir[1]);
  assign a_i    = RW'(ir[2]);
  assign b_i    = RW'(ir[3]);
  assign tgt    = ADDR_W'({ir[2], ir[3]});
  assign pc_inc = pc_q + ADDR_W'(NWORDS);

  assign ra    = rf[a_i];
  assign rb    = rf[b_i];
  assign rd    = rf[d_i];
  assign alu_b = (op == OP_LDI) ? ir[3] : rb;

  assign done  = mem_req && mem_ready;
  assign is_ld = (op == OP_LD);
  assign is_st = (op == OP_ST);
  assign pc    = pc_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op         (op),
    .a          (ra),
    .b          (alu_b),
    .result     (alu_y),
    .zero       (alu_z),
    .writes_reg (alu_wr)
  );

  // run holds the bus idle for the cycle after reset
  // so a reset always drops mem_req on the next edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:
        if (done && cnt == 2'd3)
          state_nx = S_DECODE;
      S_DECODE:
        if (op == OP_HALT)
          state_nx = S_HALTED;
        else if (is_ld || is_st)
          state_nx = S_MEM;
        else
          state_nx = S_EXEC;
      S_MEM:
        if (done) state_nx = S_EXEC;
      S_EXEC:   state_nx = S_FETCH;
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = (state == S_HALTED);
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_q + ADDR_W'(cnt);
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_addr  = tgt;
          mem_we    = is_st;
          mem_wdata = is_st ? rd : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      pc_q <= '0;
      z    <= 1'b0;
      for (int i = 0; i < NWORDS; i++)
        ir[i] <= '0;
    end else begin
      if (state == S_FETCH && done) begin
        ir[cnt] <= mem_rdata;
        cnt     <= cnt + 2'd1;
      end
      if (state == S_MEM && done && is_ld)
        z <= (mem_rdata == '0);
      if (state == S_EXEC) begin
        if (alu_wr) z <= alu_z;
        unique case (1'b1)
          (op == OP_JMP),
          (op == OP_BZ && z),
          (op == OP_BNZ && !z):
            pc_q <= tgt;
          default: pc_q <= pc_inc;
        endcase
      end
    end
  end

  // Register file carries no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_MEM && done && is_ld)
        rf[d_i] <= mem_rdata;
      else if (state == S_EXEC && alu_wr)
        rf[d_i] <= alu_y;
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: 8-bit core plus a 16-bit/4-reg core.
// Each check is an immediate assertion against hand-derived values.
module tb_cpu_mc;
  import cpu_pkg::*;

  logic        clk;
  logic        rst8, rdy8, garb;
  logic        req8, we8, halted8;
  logic [15:0] addr8, pc8;
  logic [7:0]  wd8, rd8;

  logic        rst16, rdy16;
  logic        req16, we16, halted16;
  logic [15:0] addr16, pc16, wd16, rd16;

  logic [7:0]  mem8  [65536];
  logic [15:0] mem16 [65536];

  int   n_cmp, n_bad, cyc, loop_cnt;
  bit   rnd, st_seen;
  logic [7:0] last_wd;
  logic z_at_st;

  cpu_mc #(.DATA_W(8), .ADDR_W(16), .NREGS(16)) dut (
    .clk(clk), .rst(rst8),
    .mem_addr(addr8), .mem_wdata(wd8),
    .mem_we(we8), .mem_req(req8),
    .mem_ready(rdy8), .mem_rdata(rd8),
    .halted(halted8), .pc(pc8)
  );

  cpu_mc #(.DATA_W(16), .ADDR_W(16), .NREGS(4)) dut16 (
    .clk(clk), .rst(rst16),
    .mem_addr(addr16), .mem_wdata(wd16),
    .mem_we(we16), .mem_req(req16),
    .mem_ready(rdy16), .mem_rdata(rd16),
    .halted(halted16), .pc(pc16)
  );

  assign rd8  = garb ? 8'hA5 : mem8[addr8];
  assign rd16 = mem16[addr16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: perform memory writes, track bus, hold-stability.
  task automatic tick();
    logic        w8, w16, stall;
    logic [15:0] a8, a16, sa;
    logic [7:0]  d8, swd;
    logic [15:0] d16;
    logic        swe;
    w8  = req8 && rdy8 && we8;
    a8  = addr8;
    d8  = wd8;
    w16 = req16 && rdy16 && we16;
    a16 = addr16;
    d16 = wd16;
    if (req8 && rdy8 && !we8 && addr8 == 16'h0008)
      loop_cnt++;
    if (req8 && we8) begin
      st_seen = 1'b1;
      last_wd = wd8;
      z_at_st = dut.z;
    end
    stall = req8 && !rdy8;
    sa    = addr8;
    swe   = we8;
    swd   = wd8;
    @(posedge clk);
    if (w8)  mem8[a8]   = d8;
    if (w16) mem16[a16] = d16;
    #1;
    if (rnd) rdy8 = 1'($urandom_range(0, 1));
    if (stall && req8)
      check("hold_stable", {addr8, we8, wd8},
            {sa, swe, swd});
  endtask

  task automatic reset8();
    rst8 = 1'b0;
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
  endtask

  task automatic run_until(input bit w, input int limit,
                           output int n);
    n = 0;
    while (!(w ? halted16 : halted8) && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic ld8(input int a, input logic [7:0] o,
                     input logic [7:0] d, input logic [7:0] x,
                     input logic [7:0] y);
    mem8[a]   = o;
    mem8[a+1] = d;
    mem8[a+2] = x;
    mem8[a+3] = y;
  endtask

  task automatic ld16(input int a, input logic [15:0] o,
                      input logic [15:0] d, input logic [15:0] x,
                      input logic [15:0] y);
    mem16[a]   = o;
    mem16[a+1] = d;
    mem16[a+2] = x;
    mem16[a+3] = y;
  endtask

  task automatic prog_arith();
    ld8(0,  OP_LDI, 8'd1, 8'd0, 8'd200);
    ld8(4,  OP_LDI, 8'd2, 8'd0, 8'd100);
    ld8(8,  OP_ADD, 8'd3, 8'd1, 8'd2);
    ld8(12, OP_ST,  8'd3, 8'h01, 8'h00);
    ld8(16, OP_HALT, 8'd0, 8'd0, 8'd0);
    mem8[16'h0100] = 8'hEE;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; loop_cnt = 0;
    rnd = 1'b0; st_seen = 1'b0;
    last_wd = '0; z_at_st = 1'b0;
    rst8 = 1'b0; rst16 = 1'b0;
    rdy8 = 1'b1; rdy16 = 1'b1; garb = 1'b1;
    prog_arith();

    // Reset hold with garbage read data
    repeat (3) tick();
    check("rst_req",    req8,    1'b0);
    check("rst_pc",     pc8,     16'h0);
    check("rst_halted", halted8, 1'b0);
    check("rst_addr",   addr8,   16'h0);
    rst8 = 1'b1;
    garb = 1'b0;
    tick();
    check("rel_req",  req8,  1'b1);
    check("rel_addr", addr8, 16'h0);

    // Arithmetic with wrap, ready always high
    run_until(1'b0, 200, cyc);
    check("ar_halt",  halted8, 1'b1);
    check("ar_pc",    pc8, 16'd16);
    check("ar_mem",   mem8[16'h0100], 8'h2C);
    check("ar_stwe",  st_seen, 1'b1);
    check("ar_wdata", last_wd, 8'h2C);
    check("ar_cycles", cyc, 30);
    repeat (5) tick();
    check("ar_sticky", {halted8, req8}, 2'b10);

    // Rotates
    ld8(0,  OP_LDI,  8'd1, 8'd0, 8'h81);
    ld8(4,  OP_LDI,  8'd2, 8'd0, 8'd9);
    ld8(8,  OP_LDI,  8'd5, 8'd0, 8'd0);
    ld8(12, OP_ROTL, 8'd3, 8'd1, 8'd2);
    ld8(16, OP_ROTR, 8'd4, 8'd1, 8'd2);
    ld8(20, OP_ROTL, 8'd6, 8'd1, 8'd5);
    ld8(24, OP_ST,   8'd3, 8'h03, 8'h00);
    ld8(28, OP_ST,   8'd4, 8'h03, 8'h01);
    ld8(32, OP_ST,   8'd6, 8'h03, 8'h02);
    ld8(36, OP_HALT, 8'd0, 8'd0, 8'd0);
    reset8();
    run_until(1'b0, 400, cyc);
    check("rot_pc",   pc8, 16'd36);
    check("rot_l9",   mem8[16'h0300], 8'h03);
    check("rot_r9",   mem8[16'h0301], 8'hC0);
    check("rot_l0",   mem8[16'h0302], 8'h81);

    // Branch loop
    ld8(0,  OP_LDI, 8'd1, 8'd0, 8'd3);
    ld8(4,  OP_LDI, 8'd2, 8'd0, 8'd1);
    ld8(8,  OP_SUB, 8'd1, 8'd1, 8'd2);
    ld8(12, OP_BNZ, 8'd0, 8'h00, 8'h08);
    ld8(16, OP_ST,  8'd1, 8'h02, 8'h00);
    ld8(20, OP_HALT, 8'd0, 8'd0, 8'd0);
    mem8[16'h0200] = 8'hEE;
    reset8();
    loop_cnt = 0;
    z_at_st  = 1'b0;
    run_until(1'b0, 400, cyc);
    check("br_pc",    pc8, 16'd20);
    check("br_loops", loop_cnt, 3);
    check("br_mem",   mem8[16'h0200], 8'h00);
    check("br_z",     z_at_st, 1'b1);

    // Wait states, 50% ready
    prog_arith();
    reset8();
    rnd = 1'b1;
    run_until(1'b0, 2000, cyc);
    rnd  = 1'b0;
    rdy8 = 1'b1;
    check("ws_halt", halted8, 1'b1);
    check("ws_pc",   pc8, 16'd16);
    check("ws_mem",  mem8[16'h0100], 8'h2C);

    // Reset during a stalled LD
    ld8(0, OP_LD,   8'd1, 8'h01, 8'h00);
    ld8(4, OP_HALT, 8'd0, 8'd0, 8'd0);
    mem8[16'h0100] = 8'h55;
    reset8();
    cyc = 0;
    while (!(req8 && addr8 == 16'h0100) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("mr_inmem", {req8, addr8}, {1'b1, 16'h0100});
    rdy8 = 1'b0;
    tick();
    tick();
    rst8 = 1'b0;
    tick();
    check("mr_req", req8, 1'b0);
    check("mr_pc",  pc8, 16'h0);
    rst8 = 1'b1;
    rdy8 = 1'b1;
    tick();
    check("mr_refetch", {req8, we8, addr8},
          {1'b1, 1'b0, 16'h0});
    run_until(1'b0, 200, cyc);
    check("mr_halt_pc", {halted8, pc8}, {1'b1, 16'd4});

    // 16-bit data, 4 registers
    ld16(0,  16'h0003, 16'd1, 16'd0, 16'd40000);
    ld16(4,  16'h0003, 16'd2, 16'd0, 16'd30000);
    ld16(8,  16'h0005, 16'd3, 16'd1, 16'd2);
    ld16(12, 16'h0002, 16'd3, 16'd0, 16'h0100);
    ld16(16, 16'h0000, 16'd0, 16'd0, 16'd0);
    mem16[16'h0100] = 16'hEEEE;
    rst16 = 1'b1;
    tick();
    run_until(1'b1, 200, cyc);
    check("w16_halt", halted16, 1'b1);
    check("w16_pc",   pc16, 16'd16);
    check("w16_mem",  mem16[16'h0100], 16'd4464);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
Parametrised multi-cycle accumulator-free register CPU, the successor to the current fixed 8-bit core. Instruction memory and data memory share one bus, now with a req/ready handshake instead of fixed-latency reads. The block adds:
- configurable data width, address width and register-file depth
- true rotate operations
- a zero flag with BZ/BNZ conditional branches
- a sticky halt state with a status output

It sits between the testbench/top-level memory and nothing else; it is the only bus master.

Parameters:
DATA_W, 8, data word and memory word width; instruction is 4 words.
ADDR_W, 16, memory address width; must satisfy ADDR_W <= 2*DATA_W.
NREGS, 16, register-file depth (power of 2, 2..256); index = low log2(NREGS) bits of the operand field.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  write data
mem_we  out  1  write strobe; qualified by mem_req
mem_req  out  1  bus request
mem_ready  in  1  transfer completes in any cycle where mem_req && mem_ready
mem_rdata  in  DATA_W  read data; valid in the completing cycle
halted  out  1  high while in HALTED
pc  out  ADDR_W  current PC, for debug

Behaviour:
- Reset (rst==0 at posedge):
  - state=FETCH, word counter=0, PC=0, IR=0, Z=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - Register file is not reset.
  - Reset mid-transfer drops mem_req the next cycle; any in-flight read is discarded.
- Instruction word layout, fields of DATA_W each: op | d | a | b, op fetched first from PC+0.
  - jmp_addr = low ADDR_W bits of {a,b}.
  - d_addr = low ADDR_W bits of {a,b}.
- Opcodes (8-bit):
  - HALT=00, LD=01, ST=02, LDI=03, MOV=04
  - ADD=05, SUB=06, AND=07, OR=08, XOR=09
  - ROTL=0A, ROTR=0B, JMP=0C, BZ=0D, BNZ=0E
  - Any other opcode is a NOP (PC+=4).
- States: FETCH, DECODE, MEM, EXEC, HALTED.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC+cnt (mod 2^ADDR_W).
  - On each completion, IR field[cnt] <= mem_rdata and cnt increments.
  - After the 4th completion, cnt=0 and the FSM goes to DECODE.
  - mem_req may stay high across consecutive words (back-to-back allowed).
- DECODE: mem_req=0.
  - HALT -> HALTED, PC unchanged.
  - LD or ST -> MEM.
  - Everything else -> EXEC.
- MEM:
  - mem_req=1, mem_addr=d_addr.
  - ST: mem_we=1, mem_wdata=R[d].
  - LD: R[d] <= mem_rdata on completion.
  - Hold until mem_ready, then go to EXEC.
- EXEC (single cycle), then FETCH:
  - Result width is DATA_W, wrapping. ADD/SUB are modulo 2^DATA_W.
  - ROTL/ROTR: rotate R[a] by (R[b] mod DATA_W); a shift of 0 returns R[a].
  - Z <= (result==0) for LD, LDI, MOV, ADD..ROTR. Z is unchanged for ST, JMP, BZ, BNZ, NOP.
  - PC update:
    - JMP: PC <= jmp_addr.
    - BZ taken if Z==1, BNZ taken if Z==0: PC <= jmp_addr when taken, else PC+4.
    - Others: PC <= PC+4 (wraps).
  - When d==a or d==b, the read uses the old register value.
- HALTED: halted=1, mem_req=0. Only reset leaves this state.
- mem_addr, mem_we and mem_wdata hold stable while mem_req is high and mem_ready is low.
- Minimum latency, with mem_ready held high:
  - ALU/JMP/branch: 6 cycles.
  - LD/ST: 7 cycles.
  - HALT: 5 cycles to halted=1.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams
  - state encodings
  - field slice helpers / instruction width constant (4*DATA_W)
  - This package replaces the current op_codes include.
- Sub-module: cpu_alu (combinational).
  - Inputs: op, a, b. Outputs: result, zero, writes_reg.
  - Parametrised by DATA_W.
  - The FSM, register file and bus logic stay in cpu_mc.

Test Plan:
- Reset hold: rst=0 for 3 cycles with garbage on mem_rdata -> mem_req=0, pc=0, halted=0. Release rst -> mem_addr=0, mem_req=1 on the next cycle.
- Arithmetic program, mem_ready=1: LDI r1,200; LDI r2,100; ADD r3,r1,r2; ST r3,0x0100; HALT -> mem[0x0100]=44 (wrap), halted=1 with pc=16, ST cycle shows mem_we=1 and mem_wdata=0x2C.
- Rotate, DATA_W=8: r1=0x81, r2=9; ROTL r3,r1,r2 -> 0x03. ROTR r4,r1,r2 -> 0xC0. ROTL by r5=0 -> 0x81.
- Branch loop: LDI r1,3; LDI r2,1; loop: SUB r1,r1,r2; BNZ loop; ST r1,0x0200; HALT -> loop body executes 3 times, mem[0x0200]=0, Z=1 at the ST.
- Wait states: mem_ready random with 50% duty, program as in scenario 2 -> identical memory result. mem_addr, mem_we and mem_wdata stay constant while mem_req=1 && mem_ready=0.
- Reset mid-LD: assert rst while in MEM with mem_ready=0 -> next cycle mem_req=0 and pc=0, then a clean refetch from address 0. Also: DATA_W=16, NREGS=4, ADDR_W=16 run of scenario 2 with 40000+30000 -> 4464.
